// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory controller.
// No logic: access-size codes, controller state enum and data width.
package dmem_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RSP     = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane mask, replicated store data and extended load data for one access.
// Latency: combinational. Backpressure: none, pure datapath.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]            size,
    input  logic [1:0]            lane,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rword,
    output logic [3:0]            mask,
    output logic [DATA_WIDTH-1:0] wdata_lane,
    output logic [DATA_WIDTH-1:0] rdata_ext
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            sel_b;
    logic [15:0]           sel_h;

    // Sub-size low address bits are dropped here; misalignment errors are decided upstream.
    always_comb begin
        mask       = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
        shifted    = rword >> {lane, 3'b000};
        sel_b      = shifted[7:0];
        sel_h      = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                mask       = 4'b0001 << lane;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = is_unsigned ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
            end
            SZ_HALF: begin
                mask       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
            end
            default: begin
                mask       = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller with self-clearing init; DMEM_ALIGN_CHECK_EN enables misalignment errors.
// Latency: stores/errors 1 cycle, loads READ_LATENCY cycles. Backpressure: holds response until rsp_ready.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    dmem_state_t           state;
    logic [AW-1:0]         idx;
    logic [1:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         widx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  out_of_range;
    logic                  misalign;
    logic                  acc_err;
    logic                  st_we;
    logic [3:0]            st_mask;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] st_rext;
    logic [3:0]            ld_mask;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic [DATA_WIDTH-1:0] ld_rext;
    logic                  unused_lanes;

    assign req_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign widx         = req_addr[AW+1:2];
    assign rd_word      = mem[widx];
    assign out_of_range = |(req_addr >> (AW + 2));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (req_size == SZ_HALF) ? req_addr[0]
                    : ((req_size != SZ_BYTE) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign acc_err = out_of_range | misalign;
    assign st_we   = req_ready & req_valid & req_we & ~acc_err;

    dmem_lane_align u_st_align (
        .size        (req_size),
        .lane        (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (rd_word),
        .mask        (st_mask),
        .wdata_lane  (st_wdata),
        .rdata_ext   (st_rext)
    );

    dmem_lane_align u_ld_align (
        .size        (req_size),
        .lane        (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (rd_word),
        .mask        (ld_mask),
        .wdata_lane  (ld_wdata),
        .rdata_ext   (ld_rext)
    );

    assign unused_lanes = ^{st_rext, ld_mask, ld_wdata};

    // Reset suppresses any write in the same cycle so a reset never lands a partial store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[idx] <= '0;
            end else if (st_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_mask[b]) mem[widx][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            idx       <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    idx <= idx + 1'b1;
                    if (idx == AW'(DEPTH - 1)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || req_we) ? '0 : ld_rext;
                        if (!acc_err && !req_we && (READ_LATENCY > 1)) begin
                            state    <= ST_RD_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table of single accesses plus init, stall and reset sequences.
// Built with DEPTH=256, READ_LATENCY=3; alignment expectations follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int AWID  = 32;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AWID), .READ_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vq.push_back(v);
    endtask

    // Counts rising edges until req_ready is seen; also reports whether rsp_valid ever rose.
    task automatic wait_init(output int cyc, output logic saw_rsp);
        cyc = 0;
        saw_rsp = 1'b0;
        while (cyc < 400) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (rsp_valid) saw_rsp = 1'b1;
            if (req_ready) break;
        end
    endtask

    task automatic wait_ready(output logic ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        ok = req_ready;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        logic ok;
        rd = '0; er = 1'b0; lat = 0;
        wait_ready(ok);
        if (!ok) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            lat = -1;
            return;
        end
        drive(we, sz, uns, addr, wd);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (rsp_valid) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          cyc;
        logic        saw;
        logic        ok;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("reset_busy",      {31'd0, busy}, 32'd1);
        rst = 1'b0;

        wait_init(cyc, saw);
        check("init_cycles", cyc, DEPTH);
        check("init_no_rsp", {31'd0, saw}, 32'd0);

        add("lw_top_cleared", 0, SZ_WORD, 0, 32'h3FC, 0,            32'h00000000, 0, LAT);
        add("sw_10",          1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h00000000, 0, 1);
        add("lb_13",          0, SZ_BYTE, 0, 32'h13,  0,            32'hFFFFFFDE, 0, LAT);
        add("lbu_13",         0, SZ_BYTE, 1, 32'h13,  0,            32'h000000DE, 0, LAT);
        add("lh_10",          0, SZ_HALF, 0, 32'h10,  0,            32'hFFFFBEEF, 0, LAT);
        add("lhu_12",         0, SZ_HALF, 1, 32'h12,  0,            32'h0000DEAD, 0, LAT);
        add("sb_11",          1, SZ_BYTE, 0, 32'h11,  32'h0000005A, 32'h00000000, 0, 1);
        add("lw_10_merged",   0, SZ_WORD, 0, 32'h10,  0,            32'hDEAD5AEF, 0, LAT);
        add("sw_oor",         1, SZ_WORD, 0, 32'h400, 32'h11223344, 32'h00000000, 1, 1);
        add("lw_0_no_alias",  0, SZ_WORD, 0, 32'h0,   0,            32'h00000000, 0, LAT);
        add("lw_oor",         0, SZ_WORD, 0, 32'h400, 0,            32'h00000000, 1, 1);
        add("sh_22",          1, SZ_HALF, 0, 32'h22,  32'h1234ABCD, 32'h00000000, 0, 1);
        add("lw_20",          0, SZ_WORD, 0, 32'h20,  0,            32'hABCD0000, 0, LAT);
`ifdef DMEM_ALIGN_CHECK_EN
        add("lw_12_misalign", 0, SZ_WORD, 0, 32'h12,  0,            32'h00000000, 1, 1);
`else
        add("lw_12_forced",   0, SZ_WORD, 0, 32'h12,  0,            32'hDEAD5AEF, 0, LAT);
`endif
        add("s11_30",         1, 2'b11,   0, 32'h30,  32'hCAFEF00D, 32'h00000000, 0, 1);
        add("l11_30",         0, 2'b11,   0, 32'h30,  0,            32'hCAFEF00D, 0, LAT);
        add("lb_30_pos",      0, SZ_BYTE, 0, 32'h30,  0,            32'h0000000D, 0, LAT);

        for (int i = 0; i < vq.size(); i++) begin
            xact(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, rd, er, lat);
            check({vq[i].name, "_rdata"}, rd, vq[i].exp_rdata);
            check({vq[i].name, "_err"}, {31'd0, er}, {31'd0, vq[i].exp_err});
            check({vq[i].name, "_lat"}, lat, vq[i].exp_lat);
        end

        // Response stall: data held, no new request accepted.
        wait_ready(ok);
        check("stall_ready", {31'd0, ok}, 32'd1);
        drive(1'b0, SZ_WORD, 1'b0, 32'h10, '0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            check($sformatf("stall_valid_t%0d", i), {31'd0, rsp_valid}, (i == LAT) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("stall_hold_rdata_%0d", i), rsp_rdata, 32'hDEAD5AEF);
            check($sformatf("stall_hold_ready_%0d", i), {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("stall_release_ready", {31'd0, req_ready}, 32'd1);

        // Reset while a load is waiting: response dropped, memory re-cleared.
        wait_ready(ok);
        drive(1'b0, SZ_WORD, 1'b0, 32'h10, '0);
        @(negedge clk);
        check("rdwait_busy", {31'd0, busy}, 32'd1);
        check("rdwait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        wait_init(cyc, saw);
        check("reinit_cycles", cyc, DEPTH);
        check("reinit_no_rsp", {31'd0, saw}, 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 32'h10, '0, rd, er, lat);
        check("reinit_lw_10", rd, 32'h00000000);
        check("reinit_lw_10_err", {31'd0, er}, 32'd0);
        check("reinit_lw_10_lat", lat, LAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
